// File: rtl/multicycle_control_unit.sv
// Multi-cycle RV32I(+M) control unit: sequences fetch/decode/execute/mem/mul-div/writeback
// over req/ready memories with a watchdog, flags illegal encodings, and counts retirements.
`timescale 1ns/1ps

package riscv_pkg;
  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
    ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND
  } alu_op_e;
  typedef enum logic [1:0] {SRC_A_RS1, SRC_A_PC, SRC_A_ZERO} src_a_e;
  typedef enum logic [1:0] {SRC_B_RS2, SRC_B_IMM, SRC_B_FOUR} src_b_e;
  typedef enum logic [2:0] {IMM_I, IMM_S, IMM_B, IMM_U, IMM_J} imm_type_e;
  typedef enum logic [2:0] {
    BRANCH_NONE, BRANCH_EQ, BRANCH_NE, BRANCH_LT, BRANCH_GE, BRANCH_LTU, BRANCH_GEU
  } branch_e;
  typedef enum logic [1:0] {PC_SRC_PC4, PC_SRC_BRANCH, PC_SRC_JAL, PC_SRC_JALR} pc_src_e;

  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
endpackage

module multicycle_control_unit
  import riscv_pkg::*;
#(
  parameter int ENABLE_M       = 1,
  parameter int TIMEOUT_CYCLES = 255,
  parameter int INSTRET_W      = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [31:0]          instr,
  input  logic                 imem_ready,
  input  logic                 dmem_ready,
  input  logic                 muldiv_done,
  output logic                 imem_req,
  output logic                 ir_write,
  output logic                 pc_write,
  output logic                 dmem_req,
  output logic                 dmem_we,
  output logic [2:0]           mem_width,
  output alu_op_e              alu_control,
  output src_a_e               alu_src_a_sel,
  output src_b_e               alu_src_b_sel,
  output imm_type_e            imm_type,
  output branch_e              branch_type,
  output pc_src_e              pc_src,
  output logic                 reg_write,
  output logic                 reg_src_sel,
  output logic                 reg_pc4_sel,
  output logic                 muldiv_sel,
  output logic                 muldiv_start,
  output logic                 illegal_instr,
  output logic                 bus_error,
  output logic [2:0]           state_o,
  output logic [INSTRET_W-1:0] instret
);

  typedef enum logic [2:0] {
    S_FETCH = 3'd0, S_DECODE = 3'd1, S_EXECUTE = 3'd2, S_MEM = 3'd3,
    S_MULDIV_WAIT = 3'd4, S_WRITEBACK = 3'd5, S_TRAP = 3'd7
  } state_e;

  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     wait_cnt_q, wait_cnt_d;
  logic [INSTRET_W-1:0] instret_q, instret_d;
  logic                 illegal_q, illegal_d, bus_err_q, bus_err_d;

  logic [6:0] opcode, funct7;
  logic [2:0] funct3;
  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign funct7 = instr[31:25];

  // Register indices are consumed by the datapath, not here.
  logic unused_instr_bits;
  assign unused_instr_bits = ^{instr[24:15], instr[11:7]};

  function automatic alu_op_e alu_of(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  return alt ? ALU_SUB : ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return alt ? ALU_SRA : ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

  alu_op_e   dec_alu;
  src_a_e    dec_a;
  src_b_e    dec_b;
  imm_type_e dec_imm;
  branch_e   dec_br;
  pc_src_e   dec_pc;
  logic [2:0] dec_mw;
  logic dec_legal, is_load, is_store, is_branch, is_mop, is_jump;

  always_comb begin
    dec_alu = ALU_ADD; dec_a = SRC_A_RS1; dec_b = SRC_B_RS2; dec_imm = IMM_I;
    dec_br = BRANCH_NONE; dec_pc = PC_SRC_PC4; dec_mw = 3'b010; dec_legal = 1'b1;
    is_load = 1'b0; is_store = 1'b0; is_branch = 1'b0; is_mop = 1'b0; is_jump = 1'b0;
    case (opcode)
      OP_REG: begin
        if (funct7 == 7'b0000000) dec_alu = alu_of(funct3, 1'b0);
        else if (funct7 == 7'b0100000 && (funct3 == 3'b000 || funct3 == 3'b101))
          dec_alu = alu_of(funct3, 1'b1);
        else if (funct7 == 7'b0000001 && ENABLE_M != 0) is_mop = 1'b1;
        else dec_legal = 1'b0;
      end
      OP_IMM: begin
        dec_b   = SRC_B_IMM;
        dec_alu = alu_of(funct3, funct3 == 3'b101 && instr[30]);
        if (funct3 == 3'b001) dec_legal = (funct7 == 7'b0000000);
        if (funct3 == 3'b101) dec_legal = (funct7 == 7'b0000000 || funct7 == 7'b0100000);
      end
      OP_LOAD: begin
        dec_b = SRC_B_IMM; dec_mw = funct3; is_load = 1'b1;
        dec_legal = !(funct3 == 3'b011 || funct3 == 3'b110 || funct3 == 3'b111);
      end
      OP_STORE: begin
        dec_b = SRC_B_IMM; dec_imm = IMM_S; dec_mw = funct3; is_store = 1'b1;
        dec_legal = (funct3 <= 3'b010);
      end
      OP_BRANCH: begin
        dec_alu = ALU_SUB; dec_imm = IMM_B; dec_pc = PC_SRC_BRANCH; is_branch = 1'b1;
        case (funct3)
          3'b000:  dec_br = BRANCH_EQ;
          3'b001:  dec_br = BRANCH_NE;
          3'b100:  dec_br = BRANCH_LT;
          3'b101:  dec_br = BRANCH_GE;
          3'b110:  dec_br = BRANCH_LTU;
          3'b111:  dec_br = BRANCH_GEU;
          default: dec_legal = 1'b0;
        endcase
      end
      OP_LUI:   begin dec_a = SRC_A_ZERO; dec_b = SRC_B_IMM; dec_imm = IMM_U; end
      OP_AUIPC: begin dec_a = SRC_A_PC;   dec_b = SRC_B_IMM; dec_imm = IMM_U; end
      OP_JAL: begin
        dec_a = SRC_A_PC; dec_b = SRC_B_IMM; dec_imm = IMM_J; dec_pc = PC_SRC_JAL; is_jump = 1'b1;
      end
      OP_JALR: begin
        dec_b = SRC_B_IMM; dec_pc = PC_SRC_JALR; is_jump = 1'b1;
        dec_legal = (funct3 == 3'b000);
      end
      default: dec_legal = 1'b0;
    endcase
  end

  logic imem_req_c, ir_write_c, pc_write_c, dmem_req_c, dmem_we_c, reg_write_c, muldiv_start_c;

  always_comb begin
    state_d = state_q; wait_cnt_d = '0;
    illegal_d = illegal_q; bus_err_d = bus_err_q;
    imem_req_c = 1'b0; ir_write_c = 1'b0; pc_write_c = 1'b0; dmem_req_c = 1'b0;
    dmem_we_c = 1'b0; reg_write_c = 1'b0; muldiv_start_c = 1'b0;
    case (state_q)
      S_FETCH: begin
        imem_req_c = 1'b1;
        if (imem_ready) begin
          ir_write_c = 1'b1;
          state_d    = S_DECODE;
        end else if (wait_cnt_q == WAIT_LAST) begin
          bus_err_d = 1'b1;
          state_d   = S_TRAP;
        end else wait_cnt_d = wait_cnt_q + 1'b1;
      end
      S_DECODE: begin
        if (!dec_legal) begin
          illegal_d = 1'b1;
          state_d   = S_TRAP;
        end else state_d = S_EXECUTE;
      end
      S_EXECUTE: begin
        if (is_branch) begin
          pc_write_c = 1'b1;
          state_d    = S_FETCH;
        end else if (is_load || is_store) state_d = S_MEM;
        else if (is_mop) begin
          muldiv_start_c = 1'b1;
          state_d        = S_MULDIV_WAIT;
        end else state_d = S_WRITEBACK;
      end
      S_MEM: begin
        dmem_req_c = 1'b1;
        dmem_we_c  = is_store;
        if (dmem_ready) begin
          pc_write_c = is_store;
          state_d    = is_store ? S_FETCH : S_WRITEBACK;
        end else if (wait_cnt_q == WAIT_LAST) begin
          bus_err_d = 1'b1;
          state_d   = S_TRAP;
        end else wait_cnt_d = wait_cnt_q + 1'b1;
      end
      S_MULDIV_WAIT: if (muldiv_done) state_d = S_WRITEBACK;
      S_WRITEBACK: begin
        reg_write_c = 1'b1;
        pc_write_c  = 1'b1;
        state_d     = S_FETCH;
      end
      default: state_d = S_TRAP;
    endcase
    // Every pc_write marks exactly one retired instruction.
    instret_d = instret_q + {{(INSTRET_W-1){1'b0}}, pc_write_c};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_FETCH;
      wait_cnt_q <= '0;
      instret_q  <= '0;
      illegal_q  <= 1'b0;
      bus_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      instret_q  <= instret_d;
      illegal_q  <= illegal_d;
      bus_err_q  <= bus_err_d;
    end
  end

  assign imem_req     = rst_n & imem_req_c;
  assign ir_write     = rst_n & ir_write_c;
  assign pc_write     = rst_n & pc_write_c;
  assign dmem_req     = rst_n & dmem_req_c;
  assign dmem_we      = rst_n & dmem_we_c;
  assign reg_write    = rst_n & reg_write_c;
  assign muldiv_start = rst_n & muldiv_start_c;

  // IR contents are only trustworthy once FETCH has loaded it.
  logic sel_on;
  assign sel_on = rst_n && (state_q != S_FETCH);

  always_comb begin
    alu_control = ALU_ADD; alu_src_a_sel = SRC_A_RS1; alu_src_b_sel = SRC_B_RS2;
    imm_type = IMM_I; branch_type = BRANCH_NONE; pc_src = PC_SRC_PC4; mem_width = 3'b010;
    reg_src_sel = 1'b0; reg_pc4_sel = 1'b0; muldiv_sel = 1'b0;
    if (sel_on) begin
      alu_control = dec_alu; alu_src_a_sel = dec_a; alu_src_b_sel = dec_b;
      imm_type = dec_imm; branch_type = dec_br; pc_src = dec_pc; mem_width = dec_mw;
      reg_src_sel = is_load; reg_pc4_sel = is_jump; muldiv_sel = is_mop;
    end
  end

  assign state_o       = state_q;
  assign instret       = instret_q;
  assign illegal_instr = illegal_q;
  assign bus_error     = bus_err_q;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed bench: per-instruction cycle traces built from the instruction's class and wait counts.
`timescale 1ns/1ps

module tb_multicycle_control_unit;
  import riscv_pkg::*;

  localparam int TO = 8;
  localparam logic [2:0] F = 3'd0, D = 3'd1, E = 3'd2, M = 3'd3, MW = 3'd4, WB = 3'd5, TR = 3'd7;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [31:0] instr = 32'h0;
  logic imem_ready = 1'b0, dmem_ready = 1'b0, muldiv_done = 1'b0;

  logic imem_req, ir_write, pc_write, dmem_req, dmem_we, reg_write, reg_src_sel, reg_pc4_sel;
  logic muldiv_sel, muldiv_start, illegal_instr, bus_error;
  logic [2:0] mem_width, state_o;
  logic [31:0] instret;
  alu_op_e alu_control; src_a_e alu_src_a_sel; src_b_e alu_src_b_sel;
  imm_type_e imm_type; branch_e branch_type; pc_src_e pc_src;

  logic n_imem_req, n_ir_write, n_pc_write, n_dmem_req, n_dmem_we, n_reg_write, n_reg_src_sel;
  logic n_reg_pc4_sel, n_muldiv_sel, n_muldiv_start, n_illegal_instr, n_bus_error;
  logic [2:0] n_mem_width, n_state_o;
  logic [31:0] n_instret;
  alu_op_e n_alu_control; src_a_e n_alu_src_a_sel; src_b_e n_alu_src_b_sel;
  imm_type_e n_imm_type; branch_e n_branch_type; pc_src_e n_pc_src;

  multicycle_control_unit #(.ENABLE_M(1), .TIMEOUT_CYCLES(TO), .INSTRET_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .instr(instr), .imem_ready(imem_ready), .dmem_ready(dmem_ready),
    .muldiv_done(muldiv_done), .imem_req(imem_req), .ir_write(ir_write), .pc_write(pc_write),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .mem_width(mem_width), .alu_control(alu_control),
    .alu_src_a_sel(alu_src_a_sel), .alu_src_b_sel(alu_src_b_sel), .imm_type(imm_type),
    .branch_type(branch_type), .pc_src(pc_src), .reg_write(reg_write), .reg_src_sel(reg_src_sel),
    .reg_pc4_sel(reg_pc4_sel), .muldiv_sel(muldiv_sel), .muldiv_start(muldiv_start),
    .illegal_instr(illegal_instr), .bus_error(bus_error), .state_o(state_o), .instret(instret));

  multicycle_control_unit #(.ENABLE_M(0), .TIMEOUT_CYCLES(TO), .INSTRET_W(32)) dut_nm (
    .clk(clk), .rst_n(rst_n), .instr(instr), .imem_ready(imem_ready), .dmem_ready(dmem_ready),
    .muldiv_done(muldiv_done), .imem_req(n_imem_req), .ir_write(n_ir_write), .pc_write(n_pc_write),
    .dmem_req(n_dmem_req), .dmem_we(n_dmem_we), .mem_width(n_mem_width), .alu_control(n_alu_control),
    .alu_src_a_sel(n_alu_src_a_sel), .alu_src_b_sel(n_alu_src_b_sel), .imm_type(n_imm_type),
    .branch_type(n_branch_type), .pc_src(n_pc_src), .reg_write(n_reg_write),
    .reg_src_sel(n_reg_src_sel), .reg_pc4_sel(n_reg_pc4_sel), .muldiv_sel(n_muldiv_sel),
    .muldiv_start(n_muldiv_start), .illegal_instr(n_illegal_instr), .bus_error(n_bus_error),
    .state_o(n_state_o), .instret(n_instret));

  always #5 clk = ~clk;

  logic use_nm = 1'b0;
  logic [2:0] c_st; logic [31:0] c_icnt;
  logic c_ireq, c_irw, c_pcw, c_dreq, c_dwe, c_rw, c_mst, c_ill, c_berr;
  assign c_st   = use_nm ? n_state_o : state_o;
  assign c_icnt = use_nm ? n_instret : instret;
  assign c_ireq = use_nm ? n_imem_req : imem_req;
  assign c_irw  = use_nm ? n_ir_write : ir_write;
  assign c_pcw  = use_nm ? n_pc_write : pc_write;
  assign c_dreq = use_nm ? n_dmem_req : dmem_req;
  assign c_dwe  = use_nm ? n_dmem_we : dmem_we;
  assign c_rw   = use_nm ? n_reg_write : reg_write;
  assign c_mst  = use_nm ? n_muldiv_start : muldiv_start;
  assign c_ill  = use_nm ? n_illegal_instr : illegal_instr;
  assign c_berr = use_nm ? n_bus_error : bus_error;

  typedef struct {
    logic [2:0] st;
    logic imr, dmr, mdd;
    logic ireq, irw, pcw, dreq, dwe, rw, mst, ill, berr, wb, rsrc, pc4, mds;
    logic [31:0] icnt;
  } rec_t;

  rec_t q[$];
  rec_t cur;
  logic chk_en = 1'b0;
  logic [31:0] icount = 0;
  logic m_ill = 1'b0, m_berr = 1'b0;
  int vectors = 0, miscompares = 0;
  int obs_cyc = 0, obs_dreq = 0, obs_dwe = 0, obs_mst = 0, obs_rw = 0, obs_pcw = 0;
  int s_cyc, s_dreq, s_dwe, s_mst, s_rw, s_pcw;
  alu_op_e ret_alu; logic [2:0] ret_mw, ret_st; branch_e ret_bt; pc_src_e ret_pc;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic rec_t base(input logic [2:0] st);
    rec_t r;
    r = '{default: '0};
    r.st = st; r.ill = m_ill; r.berr = m_berr; r.icnt = icount;
    return r;
  endfunction

  task automatic trap3();
    repeat (3) q.push_back(base(TR));
  endtask

  // kind: 0 alu/lui/auipc, 1 load, 2 store, 3 branch, 4 mul/div, 5 jal/jalr
  task automatic classify(input logic [31:0] ins, input bit en_m, output bit legal, output int kind);
    logic [6:0] op, f7; logic [2:0] f3;
    op = ins[6:0]; f3 = ins[14:12]; f7 = ins[31:25];
    legal = 1'b1; kind = 0;
    case (op)
      7'h33: begin
        if (f7 == 7'h01) begin legal = en_m; kind = 4; end
        else if (f7 == 7'h20) legal = (f3 == 3'd0 || f3 == 3'd5);
        else legal = (f7 == 7'h00);
      end
      7'h13: begin
        if (f3 == 3'd1) legal = (f7 == 7'h00);
        if (f3 == 3'd5) legal = (f7 == 7'h00 || f7 == 7'h20);
      end
      7'h03: begin kind = 1; legal = (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}); end
      7'h23: begin kind = 2; legal = (f3 <= 3'd2); end
      7'h63: begin kind = 3; legal = !(f3 == 3'd2 || f3 == 3'd3); end
      7'h37, 7'h17: kind = 0;
      7'h6f: kind = 5;
      7'h67: begin kind = 5; legal = (f3 == 3'd0); end
      default: legal = 1'b0;
    endcase
  endtask

  // Expected trace: iw/dw/mw = low cycles of imem_ready / dmem_ready / muldiv_done.
  task automatic build(input logic [31:0] ins, input bit en_m, input int iw, input int dw, input int mw);
    rec_t r; bit legal; int kind;
    classify(ins, en_m, legal, kind);
    r = base(F); r.ireq = 1;
    for (int i = 0; i < iw && i < TO; i++) q.push_back(r);
    if (iw >= TO) begin m_berr = 1; trap3(); return; end
    r.imr = 1; r.irw = 1; q.push_back(r);
    q.push_back(base(D));
    if (!legal) begin m_ill = 1; trap3(); return; end
    r = base(E);
    if (kind == 3) begin r.pcw = 1; q.push_back(r); icount++; return; end
    if (kind == 1 || kind == 2) begin
      q.push_back(r);
      r = base(M); r.dreq = 1; r.dwe = (kind == 2);
      for (int i = 0; i < dw && i < TO; i++) q.push_back(r);
      if (dw >= TO) begin m_berr = 1; trap3(); return; end
      r.dmr = 1;
      if (kind == 2) begin r.pcw = 1; q.push_back(r); icount++; return; end
      q.push_back(r);
    end else if (kind == 4) begin
      r.mst = 1; q.push_back(r);
      r = base(MW);
      for (int i = 0; i < mw; i++) q.push_back(r);
      r.mdd = 1; q.push_back(r);
    end else q.push_back(r);
    r = base(WB); r.rw = 1; r.pcw = 1; r.wb = 1;
    r.rsrc = (kind == 1); r.pc4 = (kind == 5); r.mds = (kind == 4);
    q.push_back(r); icount++;
  endtask

  task automatic run(input int maxn);
    int n = 0;
    while (q.size() > 0 && n < maxn) begin
      cur = q.pop_front();
      imem_ready = cur.imr; dmem_ready = cur.dmr; muldiv_done = cur.mdd;
      chk_en = 1'b1;
      @(posedge clk); #1;
      n++;
    end
    chk_en = 1'b0; imem_ready = 0; dmem_ready = 0; muldiv_done = 0;
  endtask

  task automatic snap();
    s_cyc = obs_cyc; s_dreq = obs_dreq; s_dwe = obs_dwe;
    s_mst = obs_mst; s_rw = obs_rw; s_pcw = obs_pcw;
  endtask

  task automatic do_reset();
    chk_en = 1'b0; rst_n = 1'b0;
    imem_ready = 1; dmem_ready = 1; muldiv_done = 1;
    #1;
    chk("rst_strobes", 64'({imem_req, ir_write, pc_write, dmem_req, dmem_we, reg_write, muldiv_start}), 64'd0);
    chk("rst_selects", 64'({alu_control, alu_src_a_sel, alu_src_b_sel, imm_type, branch_type, pc_src, mem_width}),
        64'({ALU_ADD, SRC_A_RS1, SRC_B_RS2, IMM_I, BRANCH_NONE, PC_SRC_PC4, 3'b010}));
    @(posedge clk); #1;
    rst_n = 1'b1; imem_ready = 0; dmem_ready = 0; muldiv_done = 0;
    icount = 0; m_ill = 0; m_berr = 0; q.delete();
    chk("rst_state", 64'(c_st), 64'd0);
    chk("rst_instret_flags", 64'({c_icnt, c_ill, c_berr}), 64'd0);
  endtask

  localparam logic [31:0] I_ADD  = 32'h002081B3, I_LW  = 32'h0000A183, I_MUL   = 32'h022081B3;
  localparam logic [31:0] I_BEQ  = 32'h00208463, I_SW  = 32'h0020A023, I_JAL   = 32'h000000EF;
  localparam logic [31:0] I_LUI  = 32'h123452B7, I_SRAI = 32'h4030D093, I_DIVU = 32'h0220D1B3;
  localparam logic [31:0] I_JALR = 32'h000100E7;
  logic [31:0] bad [8] = '{32'h0000007F, 32'h402091B3, 32'h40109093, 32'h0000B183,
                           32'h0020B023, 32'h0020A463, 32'h000010E7, 32'hFFFFFFFF};

  task automatic vec(input logic [31:0] ins, input int iw, input int dw, input int mw);
    instr = ins; snap(); build(ins, !use_nm, iw, dw, mw); run(1000);
  endtask

  initial begin
    fork
      forever begin
        @(negedge clk);
        if (chk_en) begin
          chk("state", 64'(c_st), 64'(cur.st));
          chk("strobes", 64'({c_ireq, c_irw, c_pcw, c_dreq, c_dwe, c_rw, c_mst}),
              64'({cur.ireq, cur.irw, cur.pcw, cur.dreq, cur.dwe, cur.rw, cur.mst}));
          chk("instret", 64'(c_icnt), 64'(cur.icnt));
          chk("flags", 64'({c_ill, c_berr}), 64'({cur.ill, cur.berr}));
          if (cur.wb && !use_nm)
            chk("wb_selects", 64'({reg_src_sel, reg_pc4_sel, muldiv_sel}), 64'({cur.rsrc, cur.pc4, cur.mds}));
          obs_cyc++;
          if (c_dreq) obs_dreq++;
          if (c_dwe) obs_dwe++;
          if (c_mst) obs_mst++;
          if (c_rw) obs_rw++;
          if (c_pcw) begin
            obs_pcw++;
            ret_alu = alu_control; ret_mw = mem_width; ret_bt = branch_type;
            ret_pc = pc_src; ret_st = c_st;
          end
        end
      end
    join_none

    do_reset();

    vec(I_ADD, 0, 0, 0);
    chk("add_cycles", 64'(obs_cyc - s_cyc), 64'd4);
    chk("add_alu", 64'(ret_alu), 64'(ALU_ADD));
    chk("add_retire_state", 64'(ret_st), 64'd5);
    chk("add_instret", 64'(instret), 64'd1);

    vec(I_LW, 0, 3, 0);
    chk("lw_cycles", 64'(obs_cyc - s_cyc), 64'd8);
    chk("lw_dreq_cycles", 64'(obs_dreq - s_dreq), 64'd4);
    chk("lw_dwe_cycles", 64'(obs_dwe - s_dwe), 64'd0);
    chk("lw_width", 64'(ret_mw), 64'd2);

    vec(I_MUL, 0, 0, 4);
    chk("mul_start_pulses", 64'(obs_mst - s_mst), 64'd1);
    chk("mul_cycles", 64'(obs_cyc - s_cyc), 64'd9);

    vec(I_BEQ, 0, 0, 0);
    chk("beq_cycles", 64'(obs_cyc - s_cyc), 64'd3);
    chk("beq_reg_write", 64'(obs_rw - s_rw), 64'd0);
    chk("beq_branch_type", 64'(ret_bt), 64'(BRANCH_EQ));
    chk("beq_pc_src", 64'(ret_pc), 64'(PC_SRC_BRANCH));
    chk("beq_retire_state", 64'(ret_st), 64'd2);

    vec(I_JAL, 2, 0, 0);
    chk("jal_pc_src", 64'(ret_pc), 64'(PC_SRC_JAL));
    vec(I_LUI, 0, 0, 0);
    vec(I_SRAI, 1, 0, 0);
    chk("srai_alu", 64'(ret_alu), 64'(ALU_SRA));
    vec(I_SW, 0, 1, 0);
    chk("sw_cycles", 64'(obs_cyc - s_cyc), 64'd5);
    chk("sw_reg_write", 64'(obs_rw - s_rw), 64'd0);
    vec(I_DIVU, 0, 0, 0);
    vec(I_JALR, 0, 0, 0);
    chk("instret_after_10", 64'(instret), 64'd10);

    // Reset lands in the second MEM cycle of a store.
    instr = I_SW; build(I_SW, 1, 0, 5, 0); run(4);
    rst_n = 1'b0; #1;
    chk("rst_mem_dreq_dwe", 64'({dmem_req, dmem_we}), 64'd0);
    @(posedge clk); #1; rst_n = 1'b1;
    chk("rst_mem_state", 64'(state_o), 64'd0);
    chk("rst_mem_instret", 64'(instret), 64'd0);
    icount = 0; q.delete();

    vec(I_ADD, TO, 0, 0);
    chk("ito_bus_error", 64'(bus_error), 64'd1);
    chk("ito_imem_req", 64'(imem_req), 64'd0);
    chk("ito_state", 64'(state_o), 64'd7);
    do_reset();
    vec(I_ADD, TO - 1, 0, 0);
    chk("ito_edge_no_error", 64'(bus_error), 64'd0);
    vec(I_LW, 0, TO, 0);
    chk("dto_bus_error", 64'(bus_error), 64'd1);
    do_reset();

    foreach (bad[k]) begin
      vec(bad[k], 0, 0, 0);
      chk("illegal_flag", 64'(illegal_instr), 64'd1);
      chk("illegal_no_writes", 64'((obs_rw - s_rw) + (obs_pcw - s_pcw)), 64'd0);
      do_reset();
    end

    use_nm = 1'b1;
    do_reset();
    vec(I_MUL, 0, 0, 0);
    chk("nm_mul_illegal", 64'(n_illegal_instr), 64'd1);
    chk("nm_mul_no_reg_write", 64'(obs_rw - s_rw), 64'd0);
    chk("nm_mul_no_start", 64'(obs_mst - s_mst), 64'd0);
    use_nm = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
